// File: rtl/tree_node_update_ctrl_pkg.sv
// Shared types and constants for the tree-level node update controller.
package tree_node_update_ctrl_pkg;

   localparam int NODE_WIDTH       = 40;
   localparam int NODE_ADDR        = 9;
   localparam int ENTRY_W          = NODE_ADDR + NODE_WIDTH;
   localparam int DEF_FIFO_DEPTH   = 4;
   localparam int DEF_STARVE_LIMIT = 16;
   localparam int DEF_BRAM_LAT     = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_PEND = 3'd1,
      ST_RD_PEND = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CHECK   = 3'd4
   } upd_state_e;

   typedef struct packed {
      logic [NODE_ADDR-1:0]  addr;
      logic [NODE_WIDTH-1:0] data;
   } cfg_entry_t;

endpackage

// File: rtl/tree_node_update_ctrl_upd_fifo.sv
// Pending-write queue: synchronous FIFO of {addr,data} entries, occupancy tracked by a count.
module tree_node_update_ctrl_upd_fifo
   import tree_node_update_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               RSTn,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wr_entry,
   output logic [ENTRY_W-1:0] head,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is pure data: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/tree_node_update_ctrl.sv
// Runtime node-write controller: queues host writes, steals idle lane-2 slots on BRAM port B
// for write + readback, verifies the readback and raises hold_req when starved of slots.
module tree_node_update_ctrl
   import tree_node_update_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int BRAM_LAT     = DEF_BRAM_LAT
) (
   input  logic                  clk,
   input  logic                  RSTn,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [NODE_ADDR-1:0]  cfg_addr,
   input  logic [NODE_WIDTH-1:0] cfg_data,
   input  logic                  lane_valid2,
   input  logic [NODE_ADDR-1:0]  lane_addr2,
   output logic                  bram_web,
   output logic [NODE_ADDR-1:0]  bram_addrb,
   output logic [NODE_WIDTH-1:0] bram_dinb,
   input  logic [NODE_WIDTH-1:0] bram_doutb,
   output logic                  hold_req,
   output logic                  busy,
   output logic                  upd_done,
   output logic [15:0]           upd_count,
   input  logic                  err_clr,
   output logic                  err_flag,
   output logic [NODE_ADDR-1:0]  err_addr
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   upd_state_e         state_q, state_d;
   logic [LAT_W-1:0]   lat_cnt_q;
   logic [STV_W-1:0]   starve_q;
   logic [ENTRY_W-1:0] head_bits;
   cfg_entry_t         head;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_cnt;
   logic               slot_free, in_pend, own, mismatch;

   tree_node_update_ctrl_upd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_upd_fifo (
      .clk      (clk),
      .RSTn     (RSTn),
      .push     (cfg_valid),
      .pop      (state_q == ST_CHECK),
      .wr_entry ({cfg_addr, cfg_data}),
      .head     (head_bits),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   assign head      = cfg_entry_t'(head_bits);
   assign cfg_ready = ~fifo_full;
   assign slot_free = ~lane_valid2;
   assign in_pend   = (state_q == ST_WR_PEND) || (state_q == ST_RD_PEND);
   assign own       = slot_free & in_pend;
   assign mismatch  = (state_q == ST_CHECK) && (bram_doutb != head.data);

   // Port B belongs to lane 2 except in slots the controller grabs.
   assign bram_web   = own && (state_q == ST_WR_PEND);
   assign bram_addrb = own ? head.addr : lane_addr2;
   assign bram_dinb  = bram_web ? head.data : '0;

   assign hold_req = in_pend && (starve_q >= STV_W'(STARVE_LIMIT));
   assign busy     = ~fifo_empty || (state_q != ST_IDLE);
   assign upd_done = (state_q == ST_CHECK);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (!fifo_empty) state_d = ST_WR_PEND;
         ST_WR_PEND: if (slot_free)   state_d = ST_RD_PEND;
         ST_RD_PEND: if (slot_free)   state_d = ST_WAIT;
         ST_WAIT:    if (lat_cnt_q <= LAT_W'(1)) state_d = ST_CHECK;
         ST_CHECK:   state_d = (fifo_cnt > CNT_W'(1)) ? ST_WR_PEND : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= ST_IDLE;
         lat_cnt_q <= '0;
         starve_q  <= '0;
         upd_count <= '0;
         err_flag  <= 1'b0;
         err_addr  <= '0;
      end else begin
         state_q <= state_d;

         if ((state_q == ST_RD_PEND) && slot_free)
            lat_cnt_q <= LAT_W'(BRAM_LAT - 1);
         else if ((state_q == ST_WAIT) && (lat_cnt_q != '0))
            lat_cnt_q <= lat_cnt_q - 1'b1;

         // Saturating so hold_req stays up however long the lane refuses to yield.
         if (in_pend && !slot_free) begin
            if (starve_q < STV_W'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
         end else begin
            starve_q <= '0;
         end

         if (state_q == ST_CHECK) upd_count <= upd_count + 16'd1;

         if (mismatch) begin
            err_flag <= 1'b1;
            err_addr <= head.addr;
         end else if (err_clr) begin
            err_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tree_node_update_ctrl.sv
// Bench for tree_node_update_ctrl: BRAM model on port B plus a queue-based write/verify scoreboard.
module tb_tree_node_update_ctrl;
   import tree_node_update_ctrl_pkg::*;

   localparam int DEPTH  = 4;
   localparam int SLIMIT = 16;
   localparam int LAT    = 2;

   logic                  clk = 1'b0;
   logic                  RSTn;
   logic                  cfg_valid, cfg_ready;
   logic [NODE_ADDR-1:0]  cfg_addr;
   logic [NODE_WIDTH-1:0] cfg_data;
   logic                  lane_valid2;
   logic [NODE_ADDR-1:0]  lane_addr2;
   logic                  bram_web;
   logic [NODE_ADDR-1:0]  bram_addrb;
   logic [NODE_WIDTH-1:0] bram_dinb, bram_doutb;
   logic                  hold_req, busy, upd_done;
   logic [15:0]           upd_count;
   logic                  err_clr, err_flag;
   logic [NODE_ADDR-1:0]  err_addr;

   always #5 clk = ~clk;

   tree_node_update_ctrl #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (SLIMIT),
      .BRAM_LAT     (LAT)
   ) dut (
      .clk         (clk),
      .RSTn        (RSTn),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .lane_valid2 (lane_valid2),
      .lane_addr2  (lane_addr2),
      .bram_web    (bram_web),
      .bram_addrb  (bram_addrb),
      .bram_dinb   (bram_dinb),
      .bram_doutb  (bram_doutb),
      .hold_req    (hold_req),
      .busy        (busy),
      .upd_done    (upd_done),
      .upd_count   (upd_count),
      .err_clr     (err_clr),
      .err_flag    (err_flag),
      .err_addr    (err_addr)
   );

   // Two-cycle-latency BRAM port B, optionally corrupting bit 0 of reads from 0x1FF.
   logic [NODE_WIDTH-1:0] mem [512];
   logic [NODE_WIDTH-1:0] rd1, rd2;
   logic [NODE_ADDR-1:0]  a1, a2;
   logic                  corrupt_en = 1'b0;

   always @(posedge clk) begin
      if (bram_web) mem[bram_addrb] <= bram_dinb;
      rd1 <= mem[bram_addrb];
      a1  <= bram_addrb;
      rd2 <= rd1;
      a2  <= a1;
   end
   assign bram_doutb = rd2 ^ {{(NODE_WIDTH-1){1'b0}}, corrupt_en && (a2 == 9'h1FF)};

   cfg_entry_t     exp_q[$];
   cfg_entry_t     wr_q[$];
   int             n_vec = 0;
   int             n_miss = 0;
   logic           m_err = 1'b0;
   logic [8:0]     m_err_addr = '0;
   logic [15:0]    m_cnt = '0;
   int             lane_mode = 0;
   bit             clr_on_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_lanes();
      case (lane_mode)
         1: begin lane_valid2 = 1'b1; lane_addr2 = 9'($urandom); end
         2: begin lane_valid2 = ~lane_valid2; lane_addr2 = 9'($urandom); end
         3: begin
            lane_valid2 = hold_req ? 1'b0 : ($urandom_range(0, 3) != 0);
            lane_addr2  = 9'($urandom);
         end
         default: begin lane_valid2 = 1'b0; lane_addr2 = '0; end
      endcase
   endtask

   // One clock: scoreboard checks mid-cycle, then edge, then next lane inputs.
   task automatic cycle();
      cfg_entry_t e;
      bit mis;
      #4;
      if (lane_valid2) begin
         chk("lane_web", bram_web, 0);
         chk("lane_addr", bram_addrb, lane_addr2);
         chk("lane_dinb", bram_dinb, 0);
      end
      chk("busy", busy, (exp_q.size() + wr_q.size()) != 0);
      chk("cfg_ready", cfg_ready, (exp_q.size() + wr_q.size()) < DEPTH);
      chk("err_flag", err_flag, m_err);
      chk("err_addr", err_addr, m_err_addr);
      chk("upd_count", upd_count, m_cnt);
      if (bram_web) begin
         if (exp_q.size() == 0) chk("spurious_web", bram_web, 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", bram_addrb, e.addr);
            chk("wr_data", bram_dinb, e.data);
            wr_q.push_back(e);
         end
      end
      if (upd_done) begin
         if (wr_q.size() == 0) chk("spurious_done", upd_done, 0);
         else begin
            e = wr_q.pop_front();
            mis = corrupt_en && (e.addr == 9'h1FF);
            m_cnt++;
            if (clr_on_done) err_clr = 1'b1;
            if (mis) begin m_err = 1'b1; m_err_addr = e.addr; end
            else if (err_clr) m_err = 1'b0;
         end
      end else if (err_clr) begin
         m_err = 1'b0;
      end
      @(posedge clk);
      #1;
      if (clr_on_done) err_clr = 1'b0;
      drive_lanes();
      #1;
   endtask

   task automatic push_wr(input logic [8:0] a, input logic [39:0] d);
      bit acc = 1'b0;
      cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
      for (int n = 0; n < 60; n++) begin
         acc = cfg_ready;
         cycle();
         if (acc) break;
      end
      cfg_valid = 1'b0;
      if (acc) exp_q.push_back('{addr: a, data: d});
      else chk("push_timeout", cfg_ready, 1);
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() + wr_q.size()) != 0 && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain", exp_q.size() + wr_q.size(), 0);
   endtask

   initial begin
      logic [15:0] cnt0;
      RSTn = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      lane_valid2 = 1'b0; lane_addr2 = '0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", upd_count, 0);
      chk("rst_hold", hold_req, 0);
      #1 RSTn = 1'b1;

      // 1: single write on an idle lane
      push_wr(9'h005, 40'h12_3456_789A);
      for (int j = 1; j <= 6; j++) begin
         chk("t1_web", bram_web, j == 2);
         if (j == 2) begin
            chk("t1_addr", bram_addrb, 9'h005);
            chk("t1_dinb", bram_dinb, 40'h12_3456_789A);
         end
         chk("t1_done", upd_done, j == 2 + 1 + LAT);
         cycle();
      end
      chk("t1_count", upd_count, 1);
      chk("t1_err", err_flag, 0);

      // 2: lane permanently busy -> starvation -> hold_req
      lane_mode = 1; lane_valid2 = 1'b1;
      push_wr(9'($urandom), 40'($urandom) << 8);
      for (int j = 1; j <= 20; j++) begin
         chk("t2_hold", hold_req, j >= 2 + SLIMIT);
         chk("t2_noweb", bram_web, 0);
         cycle();
      end
      lane_mode = 0; lane_valid2 = 1'b0;
      #1;
      chk("t2_hold_held", hold_req, 1);
      chk("t2_web", bram_web, 1);
      cycle();
      chk("t2_hold_fall", hold_req, 0);
      drain(40);

      // 3: overfill the queue
      cnt0 = m_cnt;
      for (int k = 0; k < 5; k++) begin
         push_wr(9'($urandom), {8'($urandom), 32'($urandom)});
         if (k == 3) chk("t3_full", cfg_ready, 0);
      end
      drain(100);
      chk("t3_count", upd_count, cnt0 + 16'd5);

      // 4: corrupted readback, then clear racing a new mismatch
      corrupt_en = 1'b1;
      push_wr(9'h1FF, {8'($urandom), 32'($urandom)});
      drain(40);
      chk("t4_flag", err_flag, 1);
      chk("t4_addr", err_addr, 9'h1FF);
      push_wr(9'h0AA, {8'($urandom), 32'($urandom)});
      drain(40);
      chk("t4_clean_keeps", err_flag, 1);
      clr_on_done = 1'b1;
      push_wr(9'h1FF, {8'($urandom), 32'($urandom)});
      drain(40);
      clr_on_done = 1'b0;
      chk("t4_set_wins", err_flag, 1);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      chk("t4_cleared", err_flag, 0);
      corrupt_en = 1'b0;

      // 6: alternating lane traffic, then random traffic honouring hold_req
      lane_mode = 2;
      for (int k = 0; k < 3; k++) push_wr(9'($urandom), {8'($urandom), 32'($urandom)});
      drain(200);
      lane_mode = 3;
      for (int k = 0; k < 6; k++) push_wr(9'($urandom), {8'($urandom), 32'($urandom)});
      drain(600);
      lane_mode = 0; lane_valid2 = 1'b0;
      cycle();

      // 5: reset while the first of three writes waits for its readback
      for (int k = 0; k < 3; k++) push_wr(9'($urandom), {8'($urandom), 32'($urandom)});
      for (int n = 0; n < 20 && wr_q.size() == 0; n++) cycle();
      cycle();
      RSTn = 1'b0;
      #1;
      exp_q.delete(); wr_q.delete();
      m_cnt = '0; m_err = 1'b0; m_err_addr = '0;
      chk("t5_cfg_ready", cfg_ready, 1);
      chk("t5_busy", busy, 0);
      chk("t5_web", bram_web, 0);
      chk("t5_addrb", bram_addrb, 0);
      chk("t5_dinb", bram_dinb, 0);
      chk("t5_hold", hold_req, 0);
      chk("t5_done", upd_done, 0);
      chk("t5_count", upd_count, 0);
      chk("t5_err", err_flag, 0);
      chk("t5_err_addr", err_addr, 0);
      repeat (2) @(posedge clk);
      #2 RSTn = 1'b1;
      for (int j = 0; j < 20; j++) begin
         chk("t5_no_done", upd_done, 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
